// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch-line controller and its PC tracker.
package fetch_pkg;

    typedef enum logic [2:0] {
        BOOT    = 3'd0,
        IDLE    = 3'd1,
        REQ     = 3'd2,
        WAIT    = 3'd3,
        DISCARD = 3'd4
    } fetch_state_t;

    localparam int LINE_BYTES     = 64;
    localparam int INSTS_PER_LINE = 16;
    localparam int LINE_OFF_W     = 6;
    // Width of the instruction-slot index inside one line.
    localparam int SKIP_W         = LINE_OFF_W - 2;

    typedef logic [SKIP_W-1:0] skip_cnt_t;

endpackage

// File: rtl/fetch_pc_tracker.sv
// Tracks the PC of the instruction at the buffer head and how many
// pre-target slots of the first post-redirect line are still to be skipped.
module fetch_pc_tracker
    import fetch_pkg::*;
#(
    parameter int               ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fifo_read_en,
    input  logic              fifo_empty,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_skip
);

    logic [ADDR_W-1:0] inst_pc_reg;
    logic [ADDR_W-1:0] inst_pc_next;
    skip_cnt_t         skip_cnt_reg;
    skip_cnt_t         skip_cnt_next;
    logic              deq;
    logic              unused_tgt_bits;

    // Targets are word aligned, so the two lowest bits carry no information.
    assign unused_tgt_bits = ^redirect_target[1:0];

    assign deq = fifo_read_en && !fifo_empty;

    // Redirect reloads the tracker and overrides any dequeue in the same cycle.
    always_comb begin
        inst_pc_next  = inst_pc_reg;
        skip_cnt_next = skip_cnt_reg;
        if (redirect_valid) begin
            inst_pc_next  = {redirect_target[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
            skip_cnt_next = redirect_target[LINE_OFF_W-1:2];
        end else if (deq) begin
            inst_pc_next = inst_pc_reg + ADDR_W'(4);
            if (skip_cnt_reg != '0) begin
                skip_cnt_next = skip_cnt_reg - 1'b1;
            end
        end
    end

    // Tracker state; boot starts at the reset line with its leading slots skipped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_pc_reg  <= {RESET_PC[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
            skip_cnt_reg <= RESET_PC[LINE_OFF_W-1:2];
        end else begin
            inst_pc_reg  <= inst_pc_next;
            skip_cnt_reg <= skip_cnt_next;
        end
    end

    assign inst_pc   = inst_pc_reg;
    assign inst_skip = (skip_cnt_reg != '0);

endmodule

// File: rtl/fetch_line_ctrl.sv
// Fetch-line controller: owns the fetch line address, issues line requests,
// forwards or squashes line returns, and clears the buffer on redirect.
module fetch_line_ctrl
    import fetch_pkg::*;
#(
    parameter int               ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_inst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              req_valid,
    output logic [ADDR_W-1:0] req_addr,
    input  logic              req_accept,
    input  logic              arb_line_valid,
    output logic              ib_line_ready,
    output logic              clear_ibuffer,
    input  logic              fifo_read_en,
    input  logic              fifo_empty,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_skip
);

    fetch_state_t      state_reg;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] line_addr_reg;
    logic [ADDR_W-1:0] line_addr_next;
    logic              pend_reg;
    logic              pend_next;
    logic              clear_reg;
    logic              clear_next;
    logic              pend_eff;

    // A fetch_inst arriving together with the line return still counts as pending.
    assign pend_eff = pend_reg || fetch_inst;

    // Next-state logic; redirect is applied last so it overrides everything else.
    always_comb begin
        state_next     = state_reg;
        line_addr_next = line_addr_reg;
        pend_next      = pend_reg;
        clear_next     = 1'b0;
        case (state_reg)
            BOOT: state_next = REQ;
            IDLE: begin
                if (fetch_inst) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                pend_next = pend_eff;
                if (req_accept) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                pend_next = pend_eff;
                if (arb_line_valid) begin
                    line_addr_next = line_addr_reg + ADDR_W'(LINE_BYTES);
                    pend_next      = 1'b0;
                    state_next     = pend_eff ? REQ : IDLE;
                end
            end
            DISCARD: begin
                pend_next = pend_eff;
                if (arb_line_valid) begin
                    state_next = REQ;
                end
            end
            default: state_next = BOOT;
        endcase

        if (redirect_valid) begin
            line_addr_next = {redirect_target[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
            pend_next      = 1'b0;
            clear_next     = 1'b1;
            if (state_reg == WAIT) begin
                state_next = arb_line_valid ? REQ : DISCARD;
            end else if (state_reg == DISCARD) begin
                state_next = DISCARD;
            end else if (state_reg == REQ && req_accept) begin
                state_next = DISCARD;
            end else begin
                state_next = REQ;
            end
        end
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= BOOT;
            line_addr_reg <= {RESET_PC[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
            pend_reg      <= 1'b0;
            clear_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            line_addr_reg <= line_addr_next;
            pend_reg      <= pend_next;
            clear_reg     <= clear_next;
        end
    end

    assign req_valid     = (state_reg == REQ);
    assign req_addr      = line_addr_reg;
    assign ib_line_ready = arb_line_valid && (state_reg == WAIT) && !redirect_valid;
    assign clear_ibuffer = clear_reg;

    fetch_pc_tracker #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_tracker (
        .clk             (clk),
        .rst_n           (rst_n),
        .fifo_read_en    (fifo_read_en),
        .fifo_empty      (fifo_empty),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .inst_pc         (inst_pc),
        .inst_skip       (inst_skip)
    );

endmodule

// File: tb/tb_fetch_line_ctrl.sv
// Bench for fetch_line_ctrl: directed vector table, a reset sequence, and
// randomized traffic checked against a transaction-level reference model.
module tb_fetch_line_ctrl;

    localparam logic [63:0] RST_PC = 64'h8000_0010;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_inst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_target = '0;
    logic        req_valid;
    logic [63:0] req_addr;
    logic        req_accept = 1'b0;
    logic        arb_line_valid = 1'b0;
    logic        ib_line_ready;
    logic        clear_ibuffer;
    logic        fifo_read_en = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [63:0] inst_pc;
    logic        inst_skip;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_line_ctrl #(
        .ADDR_W   (64),
        .RESET_PC (RST_PC)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fetch_inst      (fetch_inst),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .req_valid       (req_valid),
        .req_addr        (req_addr),
        .req_accept      (req_accept),
        .arb_line_valid  (arb_line_valid),
        .ib_line_ready   (ib_line_ready),
        .clear_ibuffer   (clear_ibuffer),
        .fifo_read_en    (fifo_read_en),
        .fifo_empty      (fifo_empty),
        .inst_pc         (inst_pc),
        .inst_skip       (inst_skip)
    );

    typedef struct {
        logic        f;
        logic        r;
        logic [63:0] t;
        logic        a;
        logic        b;
        logic        rd;
        logic        em;
        logic        e_rv;
        logic [63:0] e_addr;
        logic        e_ibr;
        logic        e_clr;
        logic [63:0] e_pc;
        logic        e_skip;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t mk(logic f, logic r, logic [63:0] t, logic a, logic b,
                                logic rd, logic em, logic e_rv, logic [63:0] e_addr,
                                logic e_ibr, logic e_clr, logic [63:0] e_pc, logic e_skip);
        vec_t v;
        v.f = f; v.r = r; v.t = t; v.a = a; v.b = b; v.rd = rd; v.em = em;
        v.e_rv = e_rv; v.e_addr = e_addr; v.e_ibr = e_ibr; v.e_clr = e_clr;
        v.e_pc = e_pc; v.e_skip = e_skip;
        return v;
    endfunction

    // Reference model: a request may be on offer, one response may be owed
    // (possibly stale), plus the fetch line, pending flag and head-PC tracker.
    logic        m_boot, m_req, m_owed, m_stale, m_pend, m_clr;
    logic [63:0] m_line, m_pc;
    int          m_skip;

    task automatic model_reset();
        m_boot = 1'b1; m_req = 1'b0; m_owed = 1'b0; m_stale = 1'b0;
        m_pend = 1'b0; m_clr = 1'b0;
        m_line = RST_PC & ~64'h3f;
        m_pc   = RST_PC & ~64'h3f;
        m_skip = int'(RST_PC[5:2]);
    endtask

    function automatic logic model_ibr(logic b, logic r);
        return b && m_owed && !m_stale && !r;
    endfunction

    task automatic model_step(logic f, logic r, logic [63:0] t, logic a, logic b,
                              logic rd, logic em);
        logic p;
        p = m_pend || f;
        if (r) begin
            m_line = t & ~64'h3f;
            m_pend = 1'b0;
            m_clr  = 1'b1;
            m_boot = 1'b0;
            if (m_req && a) begin
                m_req = 1'b0; m_owed = 1'b1; m_stale = 1'b1;
            end else if (m_owed && !m_stale && b) begin
                m_owed = 1'b0; m_req = 1'b1;
            end else if (m_owed) begin
                m_stale = 1'b1;
            end else begin
                m_req = 1'b1;
            end
        end else begin
            m_clr = 1'b0;
            if (m_boot) begin
                m_boot = 1'b0; m_req = 1'b1;
            end else if (!m_req && !m_owed) begin
                if (f) m_req = 1'b1;
            end else if (m_req) begin
                m_pend = p;
                if (a) begin
                    m_req = 1'b0; m_owed = 1'b1; m_stale = 1'b0;
                end
            end else if (b) begin
                m_owed = 1'b0;
                if (m_stale) begin
                    m_stale = 1'b0; m_req = 1'b1; m_pend = p;
                end else begin
                    m_line = m_line + 64;
                    m_req  = p;
                    m_pend = 1'b0;
                end
            end else begin
                m_pend = p;
            end
        end
        if (r) begin
            m_pc   = t & ~64'h3f;
            m_skip = int'(t[5:2]);
        end else if (rd && !em) begin
            m_pc = m_pc + 64'd4;
            if (m_skip != 0) m_skip = m_skip - 1;
        end
    endtask

    task automatic set_in(logic f, logic r, logic [63:0] t, logic a, logic b,
                          logic rd, logic em);
        fetch_inst = f; redirect_valid = r; redirect_target = t;
        req_accept = a; arb_line_valid = b; fifo_read_en = rd; fifo_empty = em;
    endtask

    task automatic cmp(string name, logic e_rv, logic [63:0] e_addr, logic e_ibr,
                       logic e_clr, logic [63:0] e_pc, logic e_skip);
        checks++;
        if (req_valid !== e_rv || req_addr !== e_addr || ib_line_ready !== e_ibr ||
            clear_ibuffer !== e_clr || inst_pc !== e_pc || inst_skip !== e_skip) begin
            errors++;
            $display("FAIL %s: got rv=%b addr=%h ibr=%b clr=%b pc=%h skip=%b, need rv=%b addr=%h ibr=%b clr=%b pc=%h skip=%b",
                     name, req_valid, req_addr, ib_line_ready, clear_ibuffer, inst_pc, inst_skip,
                     e_rv, e_addr, e_ibr, e_clr, e_pc, e_skip);
        end
    endtask

    initial begin
        logic [63:0] t;
        logic f, r, a, b, rd, em;

        vecs[0]  = mk(0,0,64'h0,                  0,0,0,0, 0,64'h8000_0000,0,0,64'h8000_0000,1);
        vecs[1]  = mk(0,0,64'h0,                  1,0,1,0, 1,64'h8000_0000,0,0,64'h8000_0000,1);
        vecs[2]  = mk(1,0,64'h0,                  0,0,1,0, 0,64'h8000_0000,0,0,64'h8000_0004,1);
        vecs[3]  = mk(1,0,64'h0,                  0,0,1,1, 0,64'h8000_0000,0,0,64'h8000_0008,1);
        vecs[4]  = mk(0,0,64'h0,                  0,1,1,0, 0,64'h8000_0000,1,0,64'h8000_0008,1);
        vecs[5]  = mk(0,0,64'h0,                  1,0,1,0, 1,64'h8000_0040,0,0,64'h8000_000c,1);
        vecs[6]  = mk(0,0,64'h0,                  0,1,0,0, 0,64'h8000_0040,1,0,64'h8000_0010,0);
        vecs[7]  = mk(0,0,64'h0,                  0,0,0,0, 0,64'h8000_0080,0,0,64'h8000_0010,0);
        vecs[8]  = mk(1,0,64'h0,                  0,0,0,0, 0,64'h8000_0080,0,0,64'h8000_0010,0);
        vecs[9]  = mk(0,0,64'h0,                  1,0,0,0, 1,64'h8000_0080,0,0,64'h8000_0010,0);
        vecs[10] = mk(0,1,64'h9000_0008,          0,0,0,0, 0,64'h8000_0080,0,0,64'h8000_0010,0);
        vecs[11] = mk(0,0,64'h0,                  0,1,0,0, 0,64'h9000_0000,0,1,64'h9000_0000,1);
        vecs[12] = mk(0,0,64'h0,                  0,0,1,0, 1,64'h9000_0000,0,0,64'h9000_0000,1);
        vecs[13] = mk(0,0,64'h0,                  1,0,1,0, 1,64'h9000_0000,0,0,64'h9000_0004,1);
        vecs[14] = mk(0,1,64'hA000_0040,          0,1,0,0, 0,64'h9000_0000,0,0,64'h9000_0008,0);
        vecs[15] = mk(0,1,64'hB000_000C,          1,0,0,0, 1,64'hA000_0040,0,1,64'hA000_0040,0);
        vecs[16] = mk(0,0,64'h0,                  0,1,0,0, 0,64'hB000_0000,0,1,64'hB000_0000,1);
        vecs[17] = mk(0,0,64'h0,                  0,0,0,0, 1,64'hB000_0000,0,0,64'hB000_0000,1);
        vecs[18] = mk(0,1,64'hFFFF_FFFF_FFFF_FFC4,0,0,1,0, 1,64'hB000_0000,0,0,64'hB000_0000,1);
        vecs[19] = mk(0,0,64'h0,                  1,0,1,0, 1,64'hFFFF_FFFF_FFFF_FFC0,0,1,64'hFFFF_FFFF_FFFF_FFC0,1);
        vecs[20] = mk(0,0,64'h0,                  0,1,0,0, 0,64'hFFFF_FFFF_FFFF_FFC0,1,0,64'hFFFF_FFFF_FFFF_FFC4,0);
        vecs[21] = mk(1,0,64'h0,                  0,0,0,0, 0,64'h0,0,0,64'hFFFF_FFFF_FFFF_FFC4,0);
        vecs[22] = mk(0,0,64'h0,                  0,0,0,0, 1,64'h0,0,0,64'hFFFF_FFFF_FFFF_FFC4,0);

        // Directed table starting from reset release.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            if (i == 0) rst_n = 1'b1;
            set_in(vecs[i].f, vecs[i].r, vecs[i].t, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].em);
            #1;
            cmp($sformatf("vec%0d", i), vecs[i].e_rv, vecs[i].e_addr, vecs[i].e_ibr,
                vecs[i].e_clr, vecs[i].e_pc, vecs[i].e_skip);
            $display("vec %0d: rv=%b addr=%h ibr=%b clr=%b pc=%h skip=%b",
                     i, req_valid, req_addr, ib_line_ready, clear_ibuffer, inst_pc, inst_skip);
        end

        // Reset while a line is outstanding; a late response must be ignored.
        @(negedge clk);
        set_in(0,0,64'h0,1,0,0,1);
        #1;
        cmp("rst_seq_accept", 1'b1, 64'h0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFC4, 1'b0);
        $display("rst_seq: accepted addr=%h", req_addr);
        @(negedge clk);
        set_in(0,0,64'h0,0,0,0,1);
        rst_n = 1'b0;
        #1;
        cmp("rst_seq_async", 1'b0, 64'h8000_0000, 1'b0, 1'b0, 64'h8000_0000, 1'b1);
        $display("rst_seq: reset asserted mid-wait");
        @(negedge clk);
        rst_n = 1'b1;
        set_in(0,0,64'h0,0,1,0,1);
        #1;
        cmp("rst_seq_late_line", 1'b0, 64'h8000_0000, 1'b0, 1'b0, 64'h8000_0000, 1'b1);
        $display("rst_seq: late line dropped, ibr=%b", ib_line_ready);
        @(negedge clk);
        set_in(0,0,64'h0,0,0,0,1);
        #1;
        cmp("rst_seq_reboot", 1'b1, 64'h8000_0000, 1'b0, 1'b0, 64'h8000_0000, 1'b1);
        $display("rst_seq: reboot request addr=%h", req_addr);

        // Randomized traffic against the reference model.
        @(negedge clk);
        rst_n = 1'b0;
        set_in(0,0,64'h0,0,0,0,1);
        model_reset();
        @(negedge clk);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst_n = (i == 1500) ? 1'b0 : 1'b1;
            if (i == 1500) model_reset();
            f  = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 15) == 0);
            t  = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) t[63:6] = '1;
            t[1:0] = 2'b00;
            a  = m_req && ($urandom_range(0, 1) == 1);
            b  = m_owed && ($urandom_range(0, 2) == 0);
            if (m_stale && b) r = 1'b0;
            rd = $urandom_range(0, 1);
            em = ($urandom_range(0, 3) == 0);
            set_in(f, r, t, a, b, rd, em);
            #1;
            cmp($sformatf("rand%0d", i), m_req, m_line, model_ibr(b, r), m_clr, m_pc, m_skip != 0);
            if (a && rst_n) $display("rand txn cycle %0d: request accepted addr=%h redirect=%b", i, req_addr, r);
            if (rst_n) model_step(f, r, t, a, b, rd, em);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
